mips_main_control: RTL and testbench
====================================

# mips_main_control

Multicycle main control unit for the MIPS datapath. A Moore state machine, with memory-ready gating, that steps each instruction through fetch, decode, execute, memory and writeback. It drives every datapath enable and the 2-bit `OpALU` code consumed by the ALU control decoder, so it is the producing end of the `OpALU` interface. It inserts wait states until instruction or data memory signals ready.

## Interface
Parameters:
- `OPCODE_W`, default 6: width of the opcode field.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  instruction register bits [31:26]; sampled only in DECODE.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `OpALU`  out  2  ALU operation class: 00 add, 01 sub, 10 use funct.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemtoReg`, `ALUSrcA`, `RegWrite`, `RegDst`  out  1 each  datapath enables/selects.
- `ALUSrcB`  out  2  ALU B mux select: 00 reg, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- `PCSource`  out  2  PC mux select: 00 ALU, 01 ALUOut, 10 jump target.
- `illegal_op`  out  1  one-cycle pulse on an unsupported opcode.

## Operation
- State register: 4 bits. States: RESET, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB, BRANCH, JUMP, ADDIEX, ADDIWB.
- Outputs are decoded from the state only, except where gated by `mem_ready` as noted. Any output not listed for a state is 0.
- **RESET**: all outputs 0. Goes to FETCH on the first clock edge after `rst_n` is high.
- **FETCH**: `MemRead`=1, `ALUSrcB`=01, `OpALU`=00. `IRWrite` and `PCWrite` equal `mem_ready`. Holds while `mem_ready`=0, then goes to DECODE.
- **DECODE**: `ALUSrcB`=11, `OpALU`=00. Next state by opcode:
  - 100011 or 101011 → MEMADR
  - 000000 → EXEC
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000 → ADDIEX (only when the macro is defined)
  - anything else → FETCH, with `illegal_op`=1 for this cycle.
- **MEMADR**: `ALUSrcA`=1, `ALUSrcB`=10, `OpALU`=00. Goes to MEMRD for LW, MEMWR for SW. The opcode is held in an internal register captured in DECODE.
- **MEMRD**: `MemRead`=1, `IorD`=1. Holds until `mem_ready`, then goes to MEMWB.
- **MEMWB**: `RegWrite`=1, `MemtoReg`=1, `RegDst`=0. Goes to FETCH.
- **MEMWR**: `MemWrite`=1, `IorD`=1. Holds until `mem_ready`, then goes to FETCH.
- **EXEC**: `ALUSrcA`=1, `ALUSrcB`=00, `OpALU`=10. Goes to RWB.
- **RWB**: `RegWrite`=1, `RegDst`=1. Goes to FETCH.
- **BRANCH**: `ALUSrcA`=1, `OpALU`=01, `PCWriteCond`=1, `PCSource`=01. Goes to FETCH.
- **JUMP**: `PCWrite`=1, `PCSource`=10. Goes to FETCH.
- `mem_ready` is ignored in all non-memory states.
- An unreachable state encoding goes to FETCH.

## Timing
- All state changes occur on the rising edge of `clk`.
- `OpALU` is stable from one rising edge to the next. The ALU control decoder samples it on the falling edge mid-state and therefore always sees a settled value.
- Cycle counts with zero wait states, FETCH to return to FETCH:
  - R-type: 4
  - LW: 5
  - SW: 4
  - BEQ: 3
  - J: 3
  - ADDI: 4
- Each cycle with `mem_ready` low in FETCH, MEMRD or MEMWR adds one cycle.
- `rst_n` low forces RESET and all-zero outputs immediately, from any state. This includes mid-wait: no `MemWrite` may remain asserted.
- `opcode` changes outside DECODE have no effect.

## Configuration
- `MAIN_CTRL_ADDI_EN` defined:
  - DECODE sends 001000 to ADDIEX.
  - ADDIEX: `ALUSrcA`=1, `ALUSrcB`=10, `OpALU`=00. Goes to ADDIWB.
  - ADDIWB: `RegWrite`=1, `RegDst`=0, `MemtoReg`=0. Goes to FETCH.
- `MAIN_CTRL_ADDI_EN` undefined: the ADDIEX and ADDIWB states are absent, and 001000 is treated as illegal.

## Structure
- Shared package `mips_ctrl_pkg`:
  - state encodings
  - opcode constants (R, LW, SW, BEQ, J, ADDI)
  - `OpALU` codes (add 00, sub 01, funct 10)
  - `ALUSrcB` and `PCSource` select codes.
- One sub-module, `ctrl_output_decode`: a purely combinational map from state plus `mem_ready` to the control word.
- The top level holds the state register, next-state logic and opcode capture register.

## Test plan
- Reset then R-type (opcode 000000), `mem_ready`=1: states FETCH, DECODE, EXEC, RWB, FETCH. `OpALU`=10 only in EXEC. `RegWrite`=1 with `RegDst`=1 in RWB.
- LW (100011) with `mem_ready` low for 3 cycles in MEMRD: `MemRead`=1 and `IorD`=1 are held for 4 cycles, then MEMWB with `MemtoReg`=1. 8 cycles total.
- BEQ (000100): BRANCH with `OpALU`=01, `PCWriteCond`=1, `PCSource`=01. Back in FETCH after 3 cycles.
- FETCH with `mem_ready`=0 for 2 cycles: `IRWrite`=0 and `PCWrite`=0 in those cycles, both 1 in the ready cycle, then DECODE.
- Opcode 111111: `illegal_op` pulses 1 cycle in DECODE, then FETCH. Opcode 001000 gives the same result with the macro undefined, and ADDIEX → ADDIWB with it defined.
- SW waiting in MEMWR with `rst_n` driven low: all outputs 0 immediately, RESET state, FETCH on the first edge after release.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multicycle MIPS main control unit:
//   - state_t      : 4-bit FSM state encodings
//   - OP_*         : primary opcode constants (instruction bits [31:26])
//   - ALUOP_*      : OpALU codes handed to the ALU control decoder
//   - ALUSRCB_*    : ALU B-operand mux selects
//   - PCSRC_*      : PC source mux selects
//   - ctrl_word_t  : bundled control word produced by ctrl_output_decode
// ADDIEX/ADDIWB encodings always exist here; they are only reachable when
// MAIN_CTRL_ADDI_EN is defined.
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_RESET  = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_EXEC   = 4'd7,
        ST_RWB    = 4'd8,
        ST_BRANCH = 4'd9,
        ST_JUMP   = 4'd10,
        ST_ADDIEX = 4'd11,
        ST_ADDIWB = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_REG     = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic       alusrca;
        logic       regwrite;
        logic       regdst;
        logic [1:0] alusrcb;
        logic [1:0] pcsource;
        logic [1:0] opalu;
    } ctrl_word_t;

endpackage

// File: rtl/ctrl_output_decode.sv
// -----------------------------------------------------------------------------
// ctrl_output_decode
// Purely combinational map from the main-control state (plus mem_ready, which
// only gates the FETCH write enables) to the datapath control word.
// Ports:
//   state     in   current FSM state
//   mem_ready in   memory completes the current access this cycle
//   ctrl      out  control word; every field not set for a state is 0
// Macro: MAIN_CTRL_ADDI_EN adds the ADDIEX/ADDIWB output decodes.
// -----------------------------------------------------------------------------
module ctrl_output_decode
    import mips_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    output ctrl_word_t ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.memread = 1'b1;
                ctrl.alusrcb = ALUSRCB_FOUR;
                ctrl.opalu   = ALUOP_ADD;
                // IR and PC may only latch once the instruction word is valid.
                ctrl.irwrite = mem_ready;
                ctrl.pcwrite = mem_ready;
            end
            ST_DECODE: begin
                // Precompute the branch target while the opcode is decoded.
                ctrl.alusrcb = ALUSRCB_IMM_SH2;
                ctrl.opalu   = ALUOP_ADD;
            end
            ST_MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = ALUSRCB_IMM;
                ctrl.opalu   = ALUOP_ADD;
            end
            ST_MEMRD: begin
                ctrl.memread = 1'b1;
                ctrl.iord    = 1'b1;
            end
            ST_MEMWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.regdst   = 1'b0;
            end
            ST_MEMWR: begin
                ctrl.memwrite = 1'b1;
                ctrl.iord     = 1'b1;
            end
            ST_EXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = ALUSRCB_REG;
                ctrl.opalu   = ALUOP_FUNCT;
            end
            ST_RWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alusrca     = 1'b1;
                ctrl.opalu       = ALUOP_SUB;
                ctrl.pcwritecond = 1'b1;
                ctrl.pcsource    = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                ctrl.pcwrite  = 1'b1;
                ctrl.pcsource = PCSRC_JUMP;
            end
`ifdef MAIN_CTRL_ADDI_EN
            ST_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = ALUSRCB_IMM;
                ctrl.opalu   = ALUOP_ADD;
            end
            ST_ADDIWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b0;
                ctrl.memtoreg = 1'b0;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_main_control.sv
// -----------------------------------------------------------------------------
// mips_main_control
// Multicycle MIPS main control unit: a Moore FSM stepping each instruction
// through fetch, decode, execute, memory and writeback, with wait states
// while instruction/data memory is not ready.
// Parameters:
//   OPCODE_W     width of the opcode field (default 6)
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   opcode       IR[31:26], only sampled in DECODE
//   mem_ready    memory completes the current access this cycle
//   OpALU        ALU operation class (00 add, 01 sub, 10 funct)
//   PCWrite .. RegDst   1-bit datapath enables/selects
//   ALUSrcB      ALU B mux select, PCSource  PC mux select
//   illegal_op   one-cycle pulse in DECODE on an unsupported opcode
// Macro: MAIN_CTRL_ADDI_EN enables ADDI (ADDIEX -> ADDIWB); without it
//        opcode 001000 is reported as illegal.
// -----------------------------------------------------------------------------
module mips_main_control
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic [1:0]          OpALU,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic                ALUSrcA,
    output logic                RegWrite,
    output logic                RegDst,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          PCSource,
    output logic                illegal_op
);

    state_t              state;
    state_t              state_nx;
    logic [OPCODE_W-1:0] op_q;
    ctrl_word_t          ctrl;

    function automatic logic op_supported(input logic [OPCODE_W-1:0] op);
        logic ok;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
`ifdef MAIN_CTRL_ADDI_EN
            OP_ADDI:                              ok = 1'b1;
`endif
            default:                              ok = 1'b0;
        endcase
        return ok;
    endfunction

    // State register. Async reset drops straight to RESET, whose outputs are
    // all zero, so no memory strobe survives a reset mid-wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RESET;
        end else begin
            state <= state_nx;
        end
    end

    // Opcode capture: MEMADR needs to know LW vs SW after the IR may have moved.
    always_ff @(posedge clk) begin
        if (state == ST_DECODE) begin
            op_q <= opcode;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = ST_FETCH;
        case (state)
            ST_RESET:  state_nx = ST_FETCH;
            ST_FETCH:  state_nx = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_nx = ST_MEMADR;
                    OP_RTYPE:     state_nx = ST_EXEC;
                    OP_BEQ:       state_nx = ST_BRANCH;
                    OP_J:         state_nx = ST_JUMP;
`ifdef MAIN_CTRL_ADDI_EN
                    OP_ADDI:      state_nx = ST_ADDIEX;
`endif
                    default:      state_nx = ST_FETCH;
                endcase
            end
            ST_MEMADR: state_nx = (op_q == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:  state_nx = mem_ready ? ST_MEMWB : ST_MEMRD;
            ST_MEMWB:  state_nx = ST_FETCH;
            ST_MEMWR:  state_nx = mem_ready ? ST_FETCH : ST_MEMWR;
            ST_EXEC:   state_nx = ST_RWB;
            ST_RWB:    state_nx = ST_FETCH;
            ST_BRANCH: state_nx = ST_FETCH;
            ST_JUMP:   state_nx = ST_FETCH;
`ifdef MAIN_CTRL_ADDI_EN
            ST_ADDIEX: state_nx = ST_ADDIWB;
            ST_ADDIWB: state_nx = ST_FETCH;
`endif
            default:   state_nx = ST_FETCH;
        endcase
    end

    // Output logic.
    ctrl_output_decode u_out (
        .state     (state),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    always_comb begin
        OpALU       = ctrl.opalu;
        PCWrite     = ctrl.pcwrite;
        PCWriteCond = ctrl.pcwritecond;
        IorD        = ctrl.iord;
        MemRead     = ctrl.memread;
        MemWrite    = ctrl.memwrite;
        IRWrite     = ctrl.irwrite;
        MemtoReg    = ctrl.memtoreg;
        ALUSrcA     = ctrl.alusrca;
        RegWrite    = ctrl.regwrite;
        RegDst      = ctrl.regdst;
        ALUSrcB     = ctrl.alusrcb;
        PCSource    = ctrl.pcsource;
        illegal_op  = (state == ST_DECODE) && !op_supported(opcode);
    end

endmodule

// File: tb/tb_mips_main_control.sv
module tb_mips_main_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic [1:0] OpALU;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, ALUSrcA, RegWrite, RegDst;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic       illegal_op;

    int checks = 0;
    int errors = 0;

    mips_main_control #(.OPCODE_W(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .OpALU       (OpALU),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .ALUSrcA     (ALUSrcA),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .ALUSrcB     (ALUSrcB),
        .PCSource    (PCSource),
        .illegal_op  (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg
    //            ALUSrcA RegWrite RegDst _ ALUSrcB _ PCSource _ OpALU _ illegal_op
    logic [16:0] obs;
    assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                  ALUSrcA, RegWrite, RegDst, ALUSrcB, PCSource, OpALU, illegal_op};

    localparam logic [16:0] E_RESET   = 17'b0000000000_00_00_00_0;
    localparam logic [16:0] E_FETCH_R = 17'b1001010000_01_00_00_0;
    localparam logic [16:0] E_FETCH_W = 17'b0001000000_01_00_00_0;
    localparam logic [16:0] E_DECODE  = 17'b0000000000_11_00_00_0;
    localparam logic [16:0] E_DEC_ILL = 17'b0000000000_11_00_00_1;
    localparam logic [16:0] E_MEMADR  = 17'b0000000100_10_00_00_0;
    localparam logic [16:0] E_MEMRD   = 17'b0011000000_00_00_00_0;
    localparam logic [16:0] E_MEMWB   = 17'b0000001010_00_00_00_0;
    localparam logic [16:0] E_MEMWR   = 17'b0010100000_00_00_00_0;
    localparam logic [16:0] E_EXEC    = 17'b0000000100_00_00_10_0;
    localparam logic [16:0] E_RWB     = 17'b0000000011_00_00_00_0;
    localparam logic [16:0] E_BRANCH  = 17'b0100000100_00_01_01_0;
    localparam logic [16:0] E_JUMP    = 17'b1000000000_00_10_00_0;
    localparam logic [16:0] E_ADDIEX  = 17'b0000000100_10_00_00_0;
    localparam logic [16:0] E_ADDIWB  = 17'b0000000010_00_00_00_0;

    task automatic chk(input string tag, input logic [16:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Check the current state's outputs mid-cycle, then advance one clock.
    task automatic cyc(input string tag, input logic [16:0] exp);
        @(negedge clk);
        chk(tag, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = 6'b000000;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cyc("reset_held", E_RESET);
        rst_n = 1'b1;
        cyc("reset_released", E_RESET);

        // R-type, zero wait: FETCH DECODE EXEC RWB
        opcode = 6'b000000;
        cyc("r_fetch", E_FETCH_R);
        cyc("r_decode", E_DECODE);
        cyc("r_exec", E_EXEC);
        cyc("r_rwb", E_RWB);

        // LW with 3 wait cycles in MEMRD; opcode changes after DECODE are ignored
        opcode = 6'b100011;
        cyc("lw_fetch", E_FETCH_R);
        cyc("lw_decode", E_DECODE);
        opcode = 6'b101011;
        cyc("lw_memadr", E_MEMADR);
        mem_ready = 1'b0;
        cyc("lw_memrd_w1", E_MEMRD);
        cyc("lw_memrd_w2", E_MEMRD);
        cyc("lw_memrd_w3", E_MEMRD);
        mem_ready = 1'b1;
        cyc("lw_memrd_rdy", E_MEMRD);
        cyc("lw_memwb", E_MEMWB);

        // BEQ
        opcode = 6'b000100;
        cyc("beq_fetch", E_FETCH_R);
        cyc("beq_decode", E_DECODE);
        cyc("beq_branch", E_BRANCH);

        // Fetch waits, then J; mem_ready low in DECODE/JUMP has no effect
        opcode    = 6'b000010;
        mem_ready = 1'b0;
        cyc("fetch_wait1", E_FETCH_W);
        cyc("fetch_wait2", E_FETCH_W);
        mem_ready = 1'b1;
        cyc("fetch_ready", E_FETCH_R);
        mem_ready = 1'b0;
        cyc("j_decode", E_DECODE);
        cyc("j_jump", E_JUMP);
        mem_ready = 1'b1;

        // Illegal opcode
        opcode = 6'b111111;
        cyc("ill_fetch", E_FETCH_R);
        cyc("ill_decode", E_DEC_ILL);

        // ADDI (back in FETCH after the illegal decode)
        opcode = 6'b001000;
        cyc("addi_fetch", E_FETCH_R);
`ifdef MAIN_CTRL_ADDI_EN
        cyc("addi_decode", E_DECODE);
        cyc("addi_ex", E_ADDIEX);
        cyc("addi_wb", E_ADDIWB);
`else
        cyc("addi_decode_ill", E_DEC_ILL);
`endif

        // SW, zero wait
        opcode = 6'b101011;
        cyc("sw_fetch", E_FETCH_R);
        cyc("sw_decode", E_DECODE);
        cyc("sw_memadr", E_MEMADR);
        cyc("sw_memwr", E_MEMWR);

        // SW stalled in MEMWR, then asynchronous reset mid-wait
        cyc("sw2_fetch", E_FETCH_R);
        cyc("sw2_decode", E_DECODE);
        cyc("sw2_memadr", E_MEMADR);
        mem_ready = 1'b0;
        cyc("sw2_memwr_w1", E_MEMWR);
        @(negedge clk);
        chk("sw2_memwr_w2", E_MEMWR);
        rst_n = 1'b0;
        #1;
        chk("async_reset_now", E_RESET);
        @(posedge clk);
        #1;
        chk("reset_hold_edge", E_RESET);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_release_same", E_RESET);
        @(posedge clk);
        #1;
        cyc("post_reset_fetch", E_FETCH_W);
        mem_ready = 1'b1;
        cyc("post_reset_fetch_rdy", E_FETCH_R);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
